mux2x1_8bits: RTL

Two-lane to one-lane byte merger, the receive-side counterpart of the 1x2 8-bit lane demultiplexer. It accepts bytes from lane 0 and lane 1, each with its own valid, and buffers each lane in a small FIFO. It re-serialises the bytes onto a single 8-bit stream in strict lane-0/lane-1 alternation, restoring the original byte order of the striped stream. It sits at the lane-deskew/merge point of the PCIe physical-layer datapath, ahead of the byte-stream consumer.

---
 rtl/mux2x1_8bits_pkg.sv | 9 +
 rtl/mux2x1_8bits_fifo_sync.sv | 45 ++++
 rtl/mux2x1_8bits.sv | 62 ++++++
 3 files changed

// File: rtl/mux2x1_8bits_pkg.sv
// mux2x1_8bits_pkg: shared widths, FIFO depth and lane indices for the two-lane byte merger.
// Lane indices double as selector values in the top level.
package mux2x1_8bits_pkg;
    localparam int DATA_W = 8;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;
endpackage

// File: rtl/mux2x1_8bits_fifo_sync.sv
// fifo_sync_8bits: per-lane synchronous FIFO with a show-ahead head and an occupancy count.
// A push into a full FIFO is accepted only when a pop frees the head on the same edge.
module fifo_sync_8bits
    import mux2x1_8bits_pkg::*;
#(
    parameter int DATA_W = mux2x1_8bits_pkg::DATA_W,
    parameter int DEPTH = mux2x1_8bits_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int PW = $clog2(DEPTH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0] r_cnt;
    logic w_wr;
    logic w_rd;
    assign empty = (r_cnt == '0);
    assign full = (r_cnt == (PW+1)'(DEPTH));
    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);
    assign dout = r_mem[r_rd];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            r_wr <= w_wr ? r_wr + 1'b1 : r_wr;
            r_rd <= w_rd ? r_rd + 1'b1 : r_rd;
            r_cnt <= r_cnt + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, w_rd};
        end
    end
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/mux2x1_8bits.sv
// mux2x1_8bits: merges two striped byte lanes back into one stream in strict lane0/lane1 order.
// Each lane is buffered in its own FIFO; only the lane whose turn it is may be popped.
module mux2x1_8bits
    import mux2x1_8bits_pkg::*;
#(
    parameter int DATA_W = mux2x1_8bits_pkg::DATA_W,
    parameter int DEPTH = mux2x1_8bits_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid0,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              overflow
);
    logic r_sel;
    logic r_valid;
    logic [DATA_W-1:0] r_data;
    logic r_ovf;
    logic [DATA_W-1:0] w_dout0;
    logic [DATA_W-1:0] w_dout1;
    logic w_empty0;
    logic w_empty1;
    logic w_full0;
    logic w_full1;
    logic w_pop0;
    logic w_pop1;
    logic w_pop;
    logic w_drop;
    assign w_pop0 = (r_sel == LANE0) && !w_empty0;
    assign w_pop1 = (r_sel == LANE1) && !w_empty1;
    assign w_pop = w_pop0 || w_pop1;
    assign w_drop = (valid0 && w_full0 && !w_pop0) || (valid1 && w_full1 && !w_pop1);
    fifo_sync_8bits #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push(valid0), .din(data_in0), .pop(w_pop0),
        .dout(w_dout0), .empty(w_empty0), .full(w_full0)
    );
    fifo_sync_8bits #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push(valid1), .din(data_in1), .pop(w_pop1),
        .dout(w_dout1), .empty(w_empty1), .full(w_full1)
    );
    // data_out holds its last byte while the current lane is starved
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel <= LANE0;
            r_valid <= 1'b0;
            r_data <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_sel <= r_sel ^ w_pop;
            r_valid <= w_pop;
            r_data <= w_pop ? (r_sel == LANE1 ? w_dout1 : w_dout0) : r_data;
            r_ovf <= r_ovf || w_drop;
        end
    end
    assign valid_out = r_valid;
    assign data_out = r_data;
    assign overflow = r_ovf;
endmodule
